// File: rtl/fast_to_slow_handshake.sv
// fast_to_slow_handshake
//   Moves a one-cycle event and a data word from fast_clk to slow_clk. It uses
//   a 4-phase req/ack handshake with a SYNC_STAGES-deep synchronizer in each
//   direction. The data bus is not synchronized. data_hold is frozen from req
//   rise until done, so the slow side can capture it directly on req_s rising.
//
//   Parameters:
//     DATA_W      - transferred word width
//     SYNC_STAGES - flops per synchronizer chain (must be >= 2)
//
//   Ports:
//     fast_clk, slow_clk - source / destination clocks (rising edge)
//     rst                - asynchronous active-high reset, both domains
//     send, data_in      - fast: one-cycle request and its word
//     busy, done         - fast: transfer in flight / completion pulse
//     drop_cnt           - fast: saturating count of sends rejected while busy
//     valid_out,data_out - slow: delivery pulse and held word
//
//   Optional feature macro: FAST_TO_SLOW_HANDSHAKE_DROP_CNT_EN
//     If the macro is defined, the drop counter is built.
//     If it is undefined, drop_cnt is tied to 0.

module fast_to_slow_handshake #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              fast_clk,
    input  logic              slow_clk,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        drop_cnt,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CLR  = 2'd2
    } state_t;

    // ---------------- source domain (fast_clk) ----------------
    state_t                  state_q;
    logic                    req_q;
    logic                    busy_q;
    logic                    done_q;
    logic [DATA_W-1:0]       data_hold_q;
    logic [SYNC_STAGES-1:0]  ack_sync_q;
    logic                    ack_s;

    // ---------------- destination domain (slow_clk) -----------
    logic [SYNC_STAGES-1:0]  req_sync_q;
    logic                    req_s;
    logic                    req_s_d_q;
    logic                    valid_q;
    logic [DATA_W-1:0]       data_out_q;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];
    assign req_s = req_sync_q[SYNC_STAGES-1];

    // ack is simply req_s, which is a flop output, so it is safe to
    // synchronize it back into the fast domain.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], req_s};
        end
    end

    // busy and done are registered alongside the state, so neither
    // has a combinational path from send.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_hold_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (send) begin
                        data_hold_q <= data_in;
                        state_q     <= REQ;
                        req_q       <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        state_q <= CLR;
                        req_q   <= 1'b0;
                    end
                end
                CLR: begin
                    if (!ack_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FAST_TO_SLOW_HANDSHAKE_DROP_CNT_EN
    logic [3:0] drop_cnt_q;
    logic [3:0] drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (send && busy_q && (drop_cnt_q != 4'hF)) begin
            drop_cnt_d = drop_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 4'd0;
`endif

    // Destination: synchronize req and detect its rising edge. The edge
    // fires once per 4-phase cycle, so each accepted send is delivered once.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            req_sync_q <= '0;
            req_s_d_q  <= 1'b0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
            req_s_d_q  <= req_s;
            valid_q    <= req_s && !req_s_d_q;
            if (req_s && !req_s_d_q) begin
                data_out_q <= data_hold_q;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign valid_out = valid_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_fast_to_slow_handshake.sv
`timescale 1ns/100ps

module tb_fast_to_slow_handshake;

    logic       fast_clk = 1'b0;
    logic       slow_clk = 1'b0;
    logic       rst      = 1'b1;
    logic       send     = 1'b0;
    logic [7:0] data_in  = '0;
    logic       busy;
    logic       done;
    logic [3:0] drop_cnt;
    logic       valid_out;
    logic [7:0] data_out;

    real slow_half = 40.0;

    fast_to_slow_handshake #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .fast_clk (fast_clk),
        .slow_clk (slow_clk),
        .rst      (rst),
        .send     (send),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .drop_cnt (drop_cnt),
        .valid_out(valid_out),
        .data_out (data_out)
    );

    initial forever #5 fast_clk = ~fast_clk;
    initial forever #(slow_half) slow_clk = ~slow_clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned n_sent = 0;
    int unsigned n_valid = 0;
    int unsigned exp_drop = 0;
    logic [7:0]  exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned drop_add(input int unsigned cur, input int unsigned n);
`ifdef FAST_TO_SLOW_HANDSHAKE_DROP_CNT_EN
        return (cur + n > 15) ? 15 : cur + n;
`else
        return 0;
`endif
    endfunction

    // Slow-domain scoreboard: pop one expected word per valid_out pulse.
    initial begin
        logic       prev_valid;
        logic [7:0] e;
        prev_valid = 1'b0;
        forever begin
            @(posedge slow_clk);
            #1;
            if (valid_out) begin
                n_valid++;
                chk("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", {24'd0, data_out}, {24'd0, e});
                end
            end
            prev_valid = valid_out;
        end
    end

    // All fast-side tasks start and end 1ns after a fast_clk rising edge.
    task automatic send_word(input logic [7:0] d, input int unsigned extra, input bit push);
        send    = 1'b1;
        data_in = d;
        if (push) begin
            exp_q.push_back(d);
            n_sent++;
        end
        @(posedge fast_clk); #1;
        for (int unsigned i = 0; i < extra; i++) begin
            data_in = ~d;
            @(posedge fast_clk); #1;
        end
        send = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget);
        bit seen;
        bit bad_busy;
        seen     = 1'b0;
        bad_busy = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) bad_busy = 1'b1;
            @(posedge fast_clk); #1;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("busy_while_in_flight", {31'd0, bad_busy}, 32'd0);
    endtask

    task automatic wait_idle(input int unsigned budget);
        bit ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge fast_clk); #1;
        end
        if (!ok) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    typedef struct {
        logic [7:0]  data;
        int unsigned extra;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{data: 8'hA5, extra: 0};
        vecs[1] = '{data: 8'h11, extra: 1};
        vecs[2] = '{data: 8'h77, extra: 3};
        vecs[3] = '{data: 8'h99, extra: 20};

        // Reset values
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_drop", {28'd0, drop_cnt}, 32'd0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        #30 rst = 1'b0;
        @(posedge fast_clk); #1;

        // Table: one accepted send followed by `extra` rejected sends
        foreach (vecs[k]) begin
            send_word(vecs[k].data, vecs[k].extra, 1'b1);
            chk("busy_after_send", {31'd0, busy}, 32'd1);
            exp_drop = drop_add(exp_drop, vecs[k].extra);
            wait_done(400);
            chk("n_valid", n_valid, n_sent);
            chk("data_held", {24'd0, data_out}, {24'd0, vecs[k].data});
            chk("drop_cnt", {28'd0, drop_cnt}, exp_drop);
            chk("busy_in_done", {31'd0, busy}, 32'd0);
            @(posedge fast_clk); #1;
            chk("done_one_cycle", {31'd0, done}, 32'd0);
        end

        // Send exactly in the done cycle
        send_word(8'hC3, 0, 1'b1);
        wait_done(400);
        send_word(8'h3C, 0, 1'b1);
        chk("done_cycle_accept", {31'd0, busy}, 32'd1);
        wait_done(400);
        chk("n_valid_dc", n_valid, n_sent);
        chk("data_dc", {24'd0, data_out}, 32'h3C);
        chk("drop_dc", {28'd0, drop_cnt}, exp_drop);
        @(posedge fast_clk); #1;

        // Reset while a transfer is in flight
        send_word(8'h66, 0, 1'b0);
        repeat (2) begin @(posedge fast_clk); #1; end
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_drop", {28'd0, drop_cnt}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
        chk("mid_rst_data", {24'd0, data_out}, 32'd0);
        exp_drop = 0;
        #20 rst = 1'b0;
        repeat (10) @(posedge slow_clk);
        @(posedge fast_clk); #1;
        chk("no_valid_after_rst", n_valid, n_sent);
        send_word(8'h5A, 0, 1'b1);
        wait_done(400);
        chk("post_rst_data", {24'd0, data_out}, 32'h5A);
        chk("post_rst_count", n_valid, n_sent);
        @(posedge fast_clk); #1;

        // Ratio/phase sweep: slow = fast/3, then slow = fast*2
        for (int unsigned phase = 0; phase < 2; phase++) begin
            #($urandom_range(0, 9));
            slow_half = (phase == 0) ? 15.0 : 2.5;
            @(posedge fast_clk); #1;
            for (int unsigned t = 0; t < 100; t++) begin
                wait_idle(400);
                send_word(8'($urandom), 0, 1'b1);
                repeat ($urandom_range(0, 3)) begin @(posedge fast_clk); #1; end
            end
            wait_idle(400);
            repeat (10) @(posedge slow_clk);
            @(posedge fast_clk); #1;
            chk("sweep_count", n_valid, n_sent);
        end
        chk("sweep_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
